result_reader: RTL

- Reader side of the result memory interface. `operation` writes results by address; `result_reader` reads them back.
- On a start pulse it walks a window of result memory entries in address order, registers each word and streams it out on a valid/ready port.
- It sits beside `result_mem` and feeds checkers, DPI scoreboards or downstream consumers, so the bench does not need to peek hierarchically into the memory array.

---
 rtl/result_reader_pkg.sv | 22 ++
 rtl/result_checker.sv | 44 ++++
 rtl/result_reader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/result_reader_pkg.sv
// Shared types and width helpers for the result memory reader.
// Contents: state_t (reader FSM states), addr_w()/len_w() width helpers.
package result_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    // Address width for a memory of the given depth.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Length width: must also encode the full-depth value.
    function automatic int unsigned len_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/result_checker.sv
// Compares each accepted word against an expected value and counts
// mismatches with a saturating counter. Only built with
// RESULT_READER_CHECK_EN defined.
// Ports: clk_i, rst_i (sync, active high), clr_i (clear on accepted start),
//        hs_i (handshake), data_i / exp_i (observed / expected word),
//        cnt_o (mismatch count).
`ifdef RESULT_READER_CHECK_EN
module result_checker #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 hs_i,
    input  logic [MEM_WIDTH-1:0] data_i,
    input  logic [MEM_WIDTH-1:0] exp_i,
    output logic [CNT_W-1:0]     cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hs_i && (data_i != exp_i) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/result_reader.sv
// Reads a window of result memory entries in address order and streams
// each registered word out on a valid/ready port.
// Ports: clk_i, rst_i (sync, active high), start_i, base_addr_i, len_i,
//        rd_addr_o / rd_data_i (async memory read), data_o, valid_o,
//        ready_i, busy_o, done_o.
// Optional (RESULT_READER_CHECK_EN): exp_data_i, mismatch_cnt_o.
module result_reader
    import result_reader_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH = 8,
    parameter  int unsigned MEM_WIDTH = 32,
    localparam int unsigned ADDR_W    = addr_w(MEM_DEPTH),
    localparam int unsigned LEN_W     = len_w(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [MEM_WIDTH-1:0] rd_data_i,
    output logic [MEM_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o
`ifdef RESULT_READER_CHECK_EN
    ,
    input  logic [MEM_WIDTH-1:0] exp_data_i,
    output logic [LEN_W-1:0]     mismatch_cnt_o
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MEM_DEPTH);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [LEN_W-1:0]     len_clamped;
    logic [MEM_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 handshake;

    assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    assign handshake   = (state_q == SEND) && ready_i;

    // Next state; registered outputs are decoded from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    ptr_d   = base_addr_i;
                    rem_d   = len_clamped;
                    state_d = (len_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                data_d  = rd_data_i;
                rem_d   = rem_q - LEN_W'(1);
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    state_d = (rem_q == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_addr_o = ptr_q;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

`ifdef RESULT_READER_CHECK_EN
    result_checker #(
        .MEM_WIDTH (MEM_WIDTH),
        .CNT_W     (LEN_W)
    ) u_checker (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  ((state_q == IDLE) && start_i),
        .hs_i   (handshake),
        .data_i (data_q),
        .exp_i  (exp_data_i),
        .cnt_o  (mismatch_cnt_o)
    );
`endif

endmodule
